// File: rtl/mmio_uart_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : mmio_uart_fifo_ctrl_if
//  Brief  : CPU load/store, retire and UART byte-stream signals of the MMIO
//           controller. irq exists only when MMIO_IRQ_EN is defined.
//  Rev    : 1.0
// ============================================================================
interface mmio_uart_fifo_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        inst_retire;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    modport master (
        output addr, wdata, we, re, inst_retire, rx_data, rx_valid, tx_ready,
`ifdef MMIO_IRQ_EN
        input  irq,
`endif
        input  rdata, rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  addr, wdata, we, re, inst_retire, rx_data, rx_valid, tx_ready,
`ifdef MMIO_IRQ_EN
        output irq,
`endif
        output rdata, rx_ready, tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : mmio_uart_fifo_ctrl
//  Brief  : MMIO block for the 3-stage core: UART RX/TX FIFOs, cycle and
//           retired-instruction counters; optional irq via MMIO_IRQ_EN.
//  Rev    : 1.0
// ============================================================================
module mmio_uart_fifo_ctrl #(
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_fifo_ctrl_if.slave bus
);
    localparam int               c_RX_AW   = $clog2(RX_DEPTH);
    localparam int               c_TX_AW   = $clog2(TX_DEPTH);
    localparam logic [c_RX_AW:0] c_RX_FULL = (c_RX_AW+1)'(RX_DEPTH);
    localparam logic [c_TX_AW:0] c_TX_FULL = (c_TX_AW+1)'(TX_DEPTH);

    localparam logic [27:0] c_OFF_STATUS = 28'h00;
    localparam logic [27:0] c_OFF_RXDATA = 28'h04;
    localparam logic [27:0] c_OFF_TXDATA = 28'h08;
    localparam logic [27:0] c_OFF_CYCLE  = 28'h10;
    localparam logic [27:0] c_OFF_INSTR  = 28'h14;
    localparam logic [27:0] c_OFF_CTRL   = 28'h18;
    localparam logic [27:0] c_OFF_LEVELS = 28'h1C;
    localparam logic [27:0] c_OFF_IRQEN  = 28'h20;

    logic        w_hit, w_rd, w_wr, w_ctrl, w_flush, w_clr_sticky;
    logic [27:0] w_off;
    logic [31:0] w_rdata_nxt;
    logic [31:0] r_rdata;

    logic [7:0]         r_rx_mem [RX_DEPTH];
    logic [c_RX_AW-1:0] r_rx_wp, r_rx_rp;
    logic [c_RX_AW:0]   r_rx_cnt;
    logic               w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

    logic [7:0]         r_tx_mem [TX_DEPTH];
    logic [c_TX_AW-1:0] r_tx_wp, r_tx_rp;
    logic [c_TX_AW:0]   r_tx_cnt;
    logic               w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_store;

    logic               r_rx_ovf, r_tx_ovf;
    logic [CNT_W-1:0]   r_cyc, r_ins;

    // Whole upper nibble selects the region; the rest is the register offset.
    assign w_hit        = bus.addr[31:28] == BASE_ADDR[31:28];
    assign w_off        = bus.addr[27:0];
    assign w_rd         = bus.re && w_hit;
    assign w_wr         = bus.we && w_hit;
    assign w_ctrl       = w_wr && (w_off == c_OFF_CTRL);
    assign w_flush      = w_ctrl && bus.wdata[1];
    assign w_clr_sticky = w_ctrl && bus.wdata[0];

    assign w_rx_full  = r_rx_cnt == c_RX_FULL;
    assign w_rx_empty = r_rx_cnt == '0;
    assign w_rx_push  = bus.rx_valid && !w_rx_full;
    assign w_rx_pop   = w_rd && (w_off == c_OFF_RXDATA) && !w_rx_empty;

    assign w_tx_full  = r_tx_cnt == c_TX_FULL;
    assign w_tx_empty = r_tx_cnt == '0;
    assign w_tx_store = w_wr && (w_off == c_OFF_TXDATA);
    assign w_tx_push  = w_tx_store && !w_tx_full;
    assign w_tx_pop   = !w_tx_empty && bus.tx_ready;

    assign bus.rx_ready = !w_rx_full;
    assign bus.tx_valid = !w_tx_empty;
    assign bus.tx_data  = r_tx_mem[r_tx_rp];
    assign bus.rdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.wdata[7:0];
    end

    // Flush overrides any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    // RX overflow means the sender kept a byte waiting a full cycle with no room.
    always_ff @(posedge clk) begin
        if (rst || w_clr_sticky) begin
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (bus.rx_valid && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
            if (w_tx_store && w_tx_full)                r_tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_ctrl) begin
            r_cyc <= '0;
            r_ins <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (bus.inst_retire) r_ins <= r_ins + 1'b1;
        end
    end

`ifdef MMIO_IRQ_EN
    logic [1:0] r_ien;
    logic       r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ien <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && (w_off == c_OFF_IRQEN)) r_ien <= bus.wdata[1:0];
            r_irq <= (r_ien[0] && !w_rx_empty) || (r_ien[1] && w_tx_empty);
        end
    end

    assign bus.irq = r_irq;
`endif

    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            c_OFF_STATUS: w_rdata_nxt = {28'b0, r_tx_ovf, r_rx_ovf, !w_rx_empty, !w_tx_full};
            c_OFF_RXDATA: if (!w_rx_empty) w_rdata_nxt = {24'b0, r_rx_mem[r_rx_rp]};
            c_OFF_CYCLE:  w_rdata_nxt = 32'(r_cyc);
            c_OFF_INSTR:  w_rdata_nxt = 32'(r_ins);
            c_OFF_LEVELS: w_rdata_nxt = {16'b0, 8'(r_tx_cnt), 8'(r_rx_cnt)};
`ifdef MMIO_IRQ_EN
            c_OFF_IRQEN:  w_rdata_nxt = {30'b0, r_ien};
`endif
            default:      w_rdata_nxt = '0;
        endcase
    end

    // One-cycle load latency, same as dmem; misses leave rdata untouched.
    always_ff @(posedge clk) begin
        if (rst)       r_rdata <= '0;
        else if (w_rd) r_rdata <= w_rdata_nxt;
    end
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_mmio_uart_fifo_ctrl
//  Brief  : Directed + random stimulus against a queue-based model, with a
//           negedge monitor scoring rdata, status outputs and TX bytes.
//  Rev    : 1.0
// ============================================================================
module tb_mmio_uart_fifo_ctrl;
    localparam int          RXD  = 8;
    localparam int          TXD  = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_uart_fifo_ctrl_if bus();

    mmio_uart_fifo_ctrl #(
        .RX_DEPTH (RXD),
        .TX_DEPTH (TXD),
        .CNT_W    (32),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          rx_ov, tx_ov, irq_m;
    logic [1:0]  ien;
    int unsigned cyc, ins;
    logic [31:0] last_rd;

    // scoreboard
    logic [31:0] rd_exp[$];
    logic [7:0]  tx_exp[$];
    logic [2:0]  st_exp[$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        rxq.delete(); txq.delete();
        rx_ov = 0; tx_ov = 0; irq_m = 0; ien = 2'b00;
        cyc = 0; ins = 0; last_rd = 0;
    endfunction

    // One clock of stimulus: inputs already on the bus, model advanced by one edge.
    task automatic step();
        logic [27:0] off;
        logic [31:0] rv;
        bit hit, rx_full, tx_full, ctrl, rx_pop, rx_push, tx_pop, tx_store, irq_n;
        off     = bus.addr[27:0];
        hit     = bus.addr[31:28] == BASE[31:28];
        rx_full = rxq.size() == RXD;
        tx_full = txq.size() == TXD;
        st_exp.push_back({irq_m, txq.size() != 0, !rx_full});
        if (bus.re) begin
            if (hit) begin
                case (off)
                    28'h00:  rv = {28'b0, tx_ov, rx_ov, rxq.size() != 0, !tx_full};
                    28'h04:  rv = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
                    28'h10:  rv = cyc;
                    28'h14:  rv = ins;
                    28'h1C:  rv = {16'b0, 8'(txq.size()), 8'(rxq.size())};
`ifdef MMIO_IRQ_EN
                    28'h20:  rv = {30'b0, ien};
`endif
                    default: rv = 32'h0;
                endcase
                last_rd = rv;
            end
            rd_exp.push_back(last_rd);
        end
        ctrl     = bus.we && hit && off == 28'h18;
        rx_pop   = bus.re && hit && off == 28'h04 && rxq.size() != 0;
        rx_push  = bus.rx_valid && !rx_full;
        tx_pop   = txq.size() != 0 && bus.tx_ready;
        tx_store = bus.we && hit && off == 28'h08;
        irq_n    = (ien[0] && rxq.size() != 0) || (ien[1] && txq.size() == 0);
        if (bus.rx_valid && rx_full && !rx_pop) rx_ov = 1;
        if (tx_store && tx_full) tx_ov = 1;
        if (ctrl && bus.wdata[0]) begin rx_ov = 0; tx_ov = 0; end
        if (tx_pop) tx_exp.push_back(txq.pop_front());
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(bus.rx_data);
        if (tx_store && !tx_full) txq.push_back(bus.wdata[7:0]);
        if (ctrl && bus.wdata[1]) begin rxq.delete(); txq.delete(); end
        cyc = ctrl ? 0 : cyc + 1;
        ins = ctrl ? 0 : ins + 32'(bus.inst_retire);
`ifdef MMIO_IRQ_EN
        if (bus.we && hit && off == 28'h20) ien = bus.wdata[1:0];
        irq_m = irq_n;
`endif
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [27:0] off);
        bus.addr = {BASE[31:28], off}; bus.re = 1; bus.we = 0;
        step();
        bus.re = 0;
    endtask

    task automatic wr(input logic [27:0] off, input logic [31:0] d);
        bus.addr = {BASE[31:28], off}; bus.we = 1; bus.re = 0; bus.wdata = d;
        step();
        bus.we = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet();
        bus.we = 0; bus.re = 0; bus.rx_valid = 0; bus.tx_ready = 0; bus.inst_retire = 0;
    endtask

    task automatic check_reset_outputs();
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("reset_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    endtask

    task automatic do_reset();
        quiet();
        step();
        rst = 1;
        repeat (2) begin @(posedge clk); #1; end
        model_reset();
        check_reset_outputs();
        rst = 0;
    endtask

    // monitor
    bit         rd_pend = 0;
    logic [2:0] st_e;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp.size() == 0) check("rdata_unexpected", bus.rdata, 32'hxxxx_xxxx);
            else                    check("rdata", bus.rdata, rd_exp.pop_front());
        end
        rd_pend = !rst && bus.re;
        if (st_exp.size() != 0) begin
            st_e = st_exp.pop_front();
`ifdef MMIO_IRQ_EN
            check("status_irq_txv_rxr", {29'b0, bus.irq, bus.tx_valid, bus.rx_ready}, {29'b0, st_e});
`else
            check("status_txv_rxr", {29'b0, 1'b0, bus.tx_valid, bus.rx_ready}, {29'b0, st_e});
`endif
        end
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (tx_exp.size() == 0) check("tx_unexpected", {24'b0, bus.tx_data}, 32'hxxxx_xxxx);
            else                    check("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_exp.pop_front()});
        end
    end

    logic [27:0] offs [9] = '{28'h00, 28'h04, 28'h08, 28'h0C, 28'h10, 28'h14, 28'h18, 28'h1C, 28'h20};

    initial begin
        int k;
        int op;
        bus.addr = 0; bus.wdata = 0; bus.rx_data = 0;
        quiet();
        model_reset();
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs();
        rst = 0;

        // reset state and cycle counter
        rd(28'h00);
        idle(1);
        rd(28'h10);

        // two RX bytes, drained plus an empty read
        bus.rx_valid = 1; bus.rx_data = 8'h41; step();
        bus.rx_data = 8'h42; step();
        bus.rx_valid = 0;
        rd(28'h04); rd(28'h04); rd(28'h04); rd(28'h00);

        // TX overflow with transmitter stalled
        for (int i = 0; i < 9; i++) wr(28'h08, 32'h60 + i);
        rd(28'h1C); rd(28'h00);
        bus.tx_ready = 1;
        idle(10);
        bus.tx_ready = 0;

        // RX backpressure: hold valid, advance byte only on acceptance
        bus.rx_valid = 1; k = 0;
        repeat (12) begin
            bus.rx_data = 8'(8'h50 + k);
            if (rxq.size() < RXD) k++;
            step();
        end
        bus.rx_valid = 0;
        rd(28'h1C); rd(28'h00);
        for (int i = 0; i < 8; i++) rd(28'h04);

        // counter clear racing a retire, then sticky clear
        bus.inst_retire = 1;
        idle(5);
        rd(28'h14);
        wr(28'h18, 32'h0);
        bus.inst_retire = 0;
        rd(28'h14); rd(28'h10);
        wr(28'h18, 32'h1);
        rd(28'h00);

`ifdef MMIO_IRQ_EN
        wr(28'h20, 32'h1);
        bus.rx_valid = 1; bus.rx_data = 8'hA5; step();
        bus.rx_valid = 0;
        idle(1);
        rd(28'h04);
        idle(2);
        rd(28'h20);
        wr(28'h20, 32'h0);
`endif

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            op = $urandom_range(0, 9);
            bus.rx_valid    = ($urandom_range(0, 1) != 0);
            bus.rx_data     = 8'($urandom);
            bus.tx_ready    = ($urandom_range(0, 3) != 0);
            bus.inst_retire = ($urandom_range(0, 1) != 0);
            bus.wdata       = $urandom;
            bus.we = 0; bus.re = 0;
            bus.addr = {BASE[31:28], offs[$urandom_range(0, 8)]};
            case (op)
                0, 1, 2: bus.re = 1;
                3, 4:    begin bus.we = 1; bus.addr = {BASE[31:28], 28'h08}; end
                5:       begin bus.we = 1; bus.addr = {BASE[31:28], 28'h18}; bus.wdata = 32'($urandom_range(0, 3)); end
                6:       begin bus.we = 1; bus.re = 1; end
                7:       begin bus.addr[31:28] = 4'h1; bus.re = 1; bus.we = ($urandom_range(0, 1) != 0); end
                8:       begin bus.we = 1; bus.addr = {BASE[31:28], 28'h20}; end
                default: ;
            endcase
            step();
        end

        // drain
        quiet();
        bus.tx_ready = 1;
        idle(TXD + 4);
        check("tx_queue_drained", 32'(tx_exp.size()), 32'h0);
        check("rd_queue_drained", 32'(rd_exp.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mmio_uart_fifo_ctrl.md
Name: mmio_uart_fifo_ctrl

Overview:
- Memory-mapped I/O controller for the 3-stage RISC-V core.
- Decodes CPU loads/stores in the 0x8000_0000 region.
- Buffers UART RX/TX bytes in parametrised FIFOs, and provides cycle and retired-instruction counters.
- Sits beside dmem in the memory/writeback path. Read data returns one cycle after the request, matching dmem/bios latency, so the wb mux treats it identically.

Parameters:
- RX_DEPTH, 8, RX FIFO entries; power of 2, >= 2
- TX_DEPTH, 8, TX FIFO entries; power of 2, >= 2
- CNT_W, 32, counter width; 1..32, zero-extended on read
- BASE_ADDR, 32'h8000_0000, MMIO region base; decode on addr[31:28] == BASE_ADDR[31:28]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- addr  in  32  CPU byte address (execute-stage ALU result)
- wdata  in  32  store data
- we  in  1  store strobe, one cycle per store
- re  in  1  load strobe, one cycle per load
- rdata  out  32  load data, valid the cycle after re
- inst_retire  in  1  pulse per retired (non-bubble) instruction
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  receiver has byte
- rx_ready  out  1  controller accepts byte
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  FIFO head valid
- tx_ready  in  1  transmitter accepts byte

Behaviour:
- Reset: both FIFOs empty; counters 0; sticky flags 0; rdata=0; tx_valid=0; rx_ready=1 (combinational !rx_full).
- Register map (offsets from BASE_ADDR):
  - 0x00 status, read-only: bit0 = TX not full, bit1 = RX not empty, bit2 = RX overflow sticky, bit3 = TX overflow sticky; rest 0.
  - 0x04 RX data: read returns {24'b0, head byte} and pops; empty read returns 0, no pop.
  - 0x08 TX data: write pushes wdata[7:0].
  - 0x10 cycle counter, read-only.
  - 0x14 instruction counter, read-only.
  - 0x18 control: any write clears both counters; wdata[0]=1 clears sticky flags; wdata[1]=1 flushes both FIFOs.
  - 0x1C levels: {16'b0, tx_count[7:0], rx_count[7:0]}.
  - Unmapped offsets read 0; writes ignored.
- Loads: re && decode hit -> rdata registered next cycle. Otherwise rdata holds its previous value.
- RX FIFO:
  - Push when rx_valid && rx_ready.
  - When full, rx_ready=0 (backpressure). RX overflow sticky is set only if rx_valid is held while full for a whole cycle in which a pop also fails.
  - Simultaneous push and pop when full: pop frees the slot next cycle; push accepted only per rx_ready that cycle.
- TX FIFO:
  - tx_valid = !tx_empty; tx_data = head, combinational.
  - Pop on tx_valid && tx_ready.
  - Store to 0x08 when full: byte dropped, TX overflow sticky set.
  - Store and pop same cycle when full: the pop happens and the store is still dropped; count stays correct.
  - Pointers wrap modulo depth. Count width is clog2(DEPTH)+1 so full and empty are distinct.
- Counters: cycle counter +1 every non-reset cycle; instruction counter +1 per inst_retire. Both wrap at 2^CNT_W.
- Control write same cycle as increment: clear wins, counter reads 0 next cycle.
- Flush same cycle as push/pop: flush wins, FIFO empty next cycle.
- Reset mid-transfer: in-flight bytes discarded, no partial state kept.
- we and re both high same cycle: store performed, load result returned; a RX pop still occurs if addr is 0x04.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- When defined:
  - Extra output port irq (1 bit) and IRQ-enable register at offset 0x20 (read/write, bits[1:0]).
  - irq registered = (en[0] && RX not empty) || (en[1] && TX empty). Reset value 0.
- When undefined: no irq port; offset 0x20 is unmapped (reads 0).

Test Plan:
- Reset, then read 0x00 -> rdata=0x1 next cycle; read 0x10 three cycles after reset release -> value 2 or 3 per read cycle, exactly matching clock count.
- Push bytes 0x41,0x42 on RX; read 0x04 twice -> 0x41 then 0x42; third read -> 0; status bit1=0.
- With tx_ready=0, store 9 bytes to 0x08 (TX_DEPTH=8) -> levels reads tx_count=8; status bit3=1, bit0=0; raise tx_ready -> 8 bytes emitted in order, 9th absent.
- Hold rx_valid for 10 bytes with no reads -> rx_ready low after 8 accepts; rx_count=8; later reads return first 8 bytes in order.
- Pulse inst_retire 5 times, then write 0x18 in the same cycle as a retire -> counter reads 0; write 0x18 with wdata=1 -> sticky flags clear.
- With MMIO_IRQ_EN: write 0x20=1, push one RX byte -> irq=1 one cycle later; read 0x04 -> irq=0 the cycle after the pop.
